// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder sequencer.
// The master issues start/a/b, and the slave (the sequencer) returns busy/done/sum/cout.
interface serial_add_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: one half-adder pair plus a registered carry, reused over W clocks.
// The LSB is processed first, and a start/busy/done handshake frames each add.
module HA (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_ra;
  logic [W-1:0]    r_rb;
  logic [W-1:0]    r_sum;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic            r_cout;

  logic w_s1, w_c1, w_s2, w_c2, w_cnext;

  HA u_ha1 (.a(r_ra[0]), .b(r_rb[0]), .s(w_s1), .c(w_c1));
  HA u_ha2 (.a(w_s1),    .b(r_carry), .s(w_s2), .c(w_c2));

  assign w_cnext = w_c1 | w_c2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_ra    <= bus.a;
            r_rb    <= bus.b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Result bits enter at the MSB, so after W shifts the LSB sits at bit 0.
          r_sum   <= {w_s2, r_sum[W-1:1]};
          r_ra    <= r_ra >> 1;
          r_rb    <= r_rb >> 1;
          r_carry <= w_cnext;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(W - 1)) begin
            r_cout  <= w_cnext;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with W=8: handshake timing, carry corners, ignored starts,
// asynchronous abort, continuous start, and an operand sweep against hand/arith references.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  serial_add_ctrl_if #(.W(W)) bus ();

  serial_add_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge while the DUT is idle, and returns on the first negedge after done.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [8:0] exp, input string tag);
    int busy_cnt;
    int waited;
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    chk({tag, "_sumclr"}, 32'(bus.sum), 32'h0);
    busy_cnt = 0;
    waited   = 0;
    while (!bus.done && waited < 20) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      waited++;
    end
    chk({tag, "_busycyc"}, 32'(busy_cnt), 32'd8);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_res"}, 32'({bus.cout, bus.sum}), 32'(exp));
    @(negedge clk);
    chk({tag, "_donefall"}, 32'(bus.done), 32'd0);
  endtask

  logic [7:0] bset [8];
  logic [8:0] ref_v;
  int         pulses;
  int         last;
  int         holds_ok;

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bset[0] = 8'h00; bset[1] = 8'h01; bset[2] = 8'h55; bset[3] = 8'h7F;
    bset[4] = 8'h80; bset[5] = 8'hAA; bset[6] = 8'hFE; bset[7] = 8'hFF;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_res",  32'({bus.cout, bus.sum}), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // 1: timing of a single add, 0x5A + 0x3C
    bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h3C;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_busy%0d", i), 32'({bus.busy, bus.done}), 32'b10);
      @(negedge clk);
    end
    chk("t1_donecyc", 32'({bus.busy, bus.done}), 32'b01);
    chk("t1_res", 32'({bus.cout, bus.sum}), 32'h096);
    @(negedge clk);
    chk("t1_donefall", 32'(bus.done), 32'd0);
    holds_ok = 1;
    repeat (4) begin
      @(negedge clk);
      if ({bus.cout, bus.sum} !== 9'h096 || bus.busy !== 1'b0) holds_ok = 0;
    end
    chk("t1_hold", 32'(holds_ok), 32'd1);

    // 2: carry corners
    run_add(8'hFF, 8'h01, 9'h100, "t2_ff01");
    run_add(8'hFF, 8'hFF, 9'h1FE, "t2_ffff");
    run_add(8'h00, 8'h00, 9'h000, "t2_0000");

    // 3: starts during RUN and DONE are ignored
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    last = 0;
    while (!bus.done && last < 20) begin
      @(negedge clk);
      last++;
    end
    chk("t3_done", 32'(bus.done), 32'd1);
    chk("t3_res", 32'({bus.cout, bus.sum}), 32'h046);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    holds_ok = 1;
    repeat (12) begin
      if (bus.done) pulses++;
      if (bus.busy || {bus.cout, bus.sum} !== 9'h046) holds_ok = 0;
      @(negedge clk);
    end
    chk("t3_extradone", 32'(pulses), 32'd0);
    chk("t3_hold", 32'(holds_ok), 32'd1);

    // 4: asynchronous abort in RUN cycle 4
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_prebusy", 32'(bus.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_done", 32'(bus.done), 32'd0);
    chk("t4_res",  32'({bus.cout, bus.sum}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    chk("t4_nodone", 32'(pulses), 32'd0);
    run_add(8'h01, 8'h02, 9'h003, "t4_after");

    // 5: start held high gives one add every 10 cycles
    bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h80;
    pulses = 0;
    last = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        chk($sformatf("t5_res%0d", pulses), 32'({bus.cout, bus.sum}), 32'h100);
        if (last >= 0) chk($sformatf("t5_gap%0d", pulses), 32'(cyc - last), 32'd10);
        last = cyc;
        pulses++;
      end
    end
    chk("t5_pulses", 32'(pulses), 32'd4);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_idle", 32'(bus.busy), 32'd0);

    // 6: sweep every a against a fixed set of b values
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        ref_v = {1'b0, 8'(ia)} + {1'b0, bset[ib]};
        run_add(8'(ia), bset[ib], ref_v, $sformatf("t6_%02h_%02h", ia, bset[ib]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
